// File: rtl/fetch_stage_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ISSUE = 2'd0;
  localparam fetch_state_t WAIT  = 2'd1;
  localparam fetch_state_t DROP  = 2'd2;
  localparam fetch_state_t FULL  = 2'd3;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus plus the IF/ID outputs seen by decode.
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;

  modport master (
    output imem_req, imem_addr, id_instr, id_pc, id_pc4, id_valid,
    input  imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, id_instr, id_pc, id_pc4, id_valid,
    output imem_rvalid, imem_rdata
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise a bubble.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] new_instr,
  input  logic [31:0] new_pc,
  input  logic [31:0] new_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= 32'd0;
      pc4   <= 32'd4;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (!hold) begin
      if (load) begin
        valid <= 1'b1;
        instr <= new_instr;
        pc    <= new_pc;
        pc4   <= new_pc4;
      end else begin
        // bubble keeps the last pc/pc4 so decode still sees a sane address
        valid <= 1'b0;
        instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, single-outstanding imem FSM, one-entry stall buffer, IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  fetch_stage_if.master bus
);

  localparam logic [31:0] START_PC = RESET_PC & ~32'h3;

  fetch_state_t state, state_nx;
  logic [31:0]  pc, pc_nx, pc4, target;
  logic [31:0]  hold_instr, hold_nx;
  logic         deliver;
  logic [31:0]  deliver_instr;

  always_comb begin
    pc4           = pc + 32'd4;
    target        = redirect_pc & ~32'h3;
    state_nx      = state;
    pc_nx         = pc;
    hold_nx       = hold_instr;
    deliver       = 1'b0;
    deliver_instr = hold_instr;
    bus.imem_req  = 1'b0;
    bus.imem_addr = pc;
    case (state)
      ISSUE: begin
        if (redirect) begin
          pc_nx = target;
        end else begin
          bus.imem_req = 1'b1;
          state_nx     = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_nx    = target;
          state_nx = bus.imem_rvalid ? ISSUE : DROP;
        end else if (bus.imem_rvalid) begin
          if (stall) begin
            hold_nx  = bus.imem_rdata;
            state_nx = FULL;
          end else begin
            // back-to-back: next request goes out in the same cycle as the response
            deliver       = 1'b1;
            deliver_instr = bus.imem_rdata;
            pc_nx         = pc4;
            bus.imem_req  = 1'b1;
            bus.imem_addr = pc4;
          end
        end
      end
      DROP: begin
        if (redirect) pc_nx = target;
        if (bus.imem_rvalid) state_nx = ISSUE;
      end
      FULL: begin
        if (redirect) begin
          pc_nx    = target;
          state_nx = ISSUE;
        end else if (!stall) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr;
          pc_nx         = pc4;
          state_nx      = ISSUE;
        end
      end
      default: state_nx = ISSUE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ISSUE;
      pc         <= START_PC;
      hold_instr <= 32'd0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      hold_instr <= hold_nx;
    end
  end

  fetch_stage_if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .hold      (stall),
    .load      (deliver),
    .new_instr (deliver_instr),
    .new_pc    (pc),
    .new_pc4   (pc4),
    .instr     (bus.id_instr),
    .pc        (bus.id_pc),
    .pc4       (bus.id_pc4),
    .valid     (bus.id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-configurable instruction memory model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad   = 0;

  int          mem_lat = 1;
  bit          stale_inject = 0;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory answers addr|0x13 mem_lat cycles after each request
  initial begin
    bit          req_seen;
    bit          pending;
    int          cnt;
    logic [31:0] req_addr;
    logic [31:0] paddr;
    pending = 0;
    cnt = 0;
    paddr = 32'd0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      #4;
      req_seen = bus.imem_req && !rst;
      req_addr = bus.imem_addr;
      @(posedge clk);
      #1;
      if (bus.imem_rvalid) pending = 0;
      bus.imem_rvalid = 1'b0;
      if (rst) pending = 0;
      else if (req_seen) begin
        pending = 1;
        cnt = mem_lat;
        paddr = req_addr;
      end
      if (stale_inject) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_0013;
        stale_inject = 0;
      end else if (pending) begin
        cnt--;
        if (cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = paddr | 32'h13;
        end
      end
    end
  end

  task automatic do_reset(input int lat);
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    mem_lat = lat;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset(1);
    #1;
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%h exp=0", bus.id_valid); end
    total++; if (bus.id_instr !== 32'h13) begin bad++; $display("[TB] FAIL reset_instr got=%h exp=00000013", bus.id_instr); end
    total++; if (bus.id_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h exp=0", bus.id_pc); end
    total++; if (bus.id_pc4 !== 32'h4) begin bad++; $display("[TB] FAIL reset_pc4 got=%h exp=4", bus.id_pc4); end
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin bad++; $display("[TB] FAIL reset_req got=%h/%h exp=1/00000100", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_startup;
    logic [31:0] e;
    do_reset(1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      #1;
      e = 32'h100 + 32'(4 * c);
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== e) begin bad++; $display("[TB] FAIL startup_req c=%0d got=%h/%h exp=1/%h", c, bus.imem_req, bus.imem_addr, e); end
      if (c >= 2) begin
        e = 32'h100 + 32'(4 * (c - 2));
        total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== e || bus.id_pc4 !== e + 32'd4 || bus.id_instr !== (e | 32'h13)) begin
          bad++; $display("[TB] FAIL startup_id c=%0d got=%h/%h/%h/%h exp=1/%h/%h/%h", c, bus.id_valid, bus.id_pc, bus.id_pc4, bus.id_instr, e, e + 32'd4, e | 32'h13);
        end
      end else begin
        total++; if (bus.id_valid !== 1'b0) begin bad++; $display("[TB] FAIL startup_empty c=%0d got=%h exp=0", c, bus.id_valid); end
      end
    end
  endtask

  task automatic test_stall;
    bit          st  [7] = '{1, 1, 1, 0, 0, 0, 0};
    bit          rq  [7] = '{0, 0, 0, 0, 1, 1, 1};
    logic [31:0] ad  [7] = '{0, 0, 0, 0, 32'h108, 32'h10C, 32'h110};
    bit          vl  [7] = '{1, 1, 1, 1, 1, 0, 1};
    logic [31:0] ip  [7] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h104, 0, 32'h108};
    do_reset(1);
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      stall = st[i];
      #1;
      total++; if (bus.imem_req !== rq[i] || (rq[i] && bus.imem_addr !== ad[i])) begin bad++; $display("[TB] FAIL stall_req c=%0d got=%h/%h exp=%h/%h", i + 2, bus.imem_req, bus.imem_addr, rq[i], ad[i]); end
      if (vl[i]) begin
        total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== ip[i] || bus.id_pc4 !== ip[i] + 32'd4 || bus.id_instr !== (ip[i] | 32'h13)) begin
          bad++; $display("[TB] FAIL stall_id c=%0d got=%h/%h/%h/%h exp=1/%h", i + 2, bus.id_valid, bus.id_pc, bus.id_pc4, bus.id_instr, ip[i]);
        end
      end else begin
        total++; if (bus.id_valid !== 1'b0 || bus.id_instr !== 32'h13) begin bad++; $display("[TB] FAIL stall_bubble c=%0d got=%h/%h exp=0/00000013", i + 2, bus.id_valid, bus.id_instr); end
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_redirect_inflight;
    bit          rq [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
    logic [31:0] ad [8] = '{0, 0, 0, 32'h200, 0, 0, 32'h204, 0};
    do_reset(3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      redirect = (i == 0);
      redirect_pc = (i == 0) ? 32'h0000_0203 : 32'd0;
      #1;
      total++; if (bus.imem_req !== rq[i] || (rq[i] && bus.imem_addr !== ad[i])) begin bad++; $display("[TB] FAIL redir_req c=%0d got=%h/%h exp=%h/%h", i + 1, bus.imem_req, bus.imem_addr, rq[i], ad[i]); end
      if (i < 7) begin
        total++; if (bus.id_valid !== 1'b0) begin bad++; $display("[TB] FAIL redir_empty c=%0d got=%h exp=0", i + 1, bus.id_valid); end
      end else begin
        total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h200 || bus.id_pc4 !== 32'h204 || bus.id_instr !== 32'h213) begin
          bad++; $display("[TB] FAIL redir_target got=%h/%h/%h/%h exp=1/00000200/00000204/00000213", bus.id_valid, bus.id_pc, bus.id_pc4, bus.id_instr);
        end
      end
    end
  endtask

  task automatic test_stall_redirect;
    do_reset(1);
    repeat (2) @(negedge clk);
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h80;
    #1;
    total++; if (bus.id_valid !== 1'b1 || bus.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL sr_pre got=%h/%h exp=1/0", bus.id_valid, bus.imem_req); end
    @(negedge clk);
    stall = 1'b0;
    redirect = 1'b0;
    #1;
    total++; if (bus.id_valid !== 1'b0 || bus.id_instr !== 32'h13) begin bad++; $display("[TB] FAIL sr_flush got=%h/%h exp=0/00000013", bus.id_valid, bus.id_instr); end
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h80) begin bad++; $display("[TB] FAIL sr_req got=%h/%h exp=1/00000080", bus.imem_req, bus.imem_addr); end
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h80 || bus.id_instr !== 32'h93) begin bad++; $display("[TB] FAIL sr_target got=%h/%h/%h exp=1/00000080/00000093", bus.id_valid, bus.id_pc, bus.id_instr); end
  endtask

  task automatic test_wrap;
    do_reset(1);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_req0 got=%h/%h exp=1/fffffffc", bus.imem_req, bus.imem_addr); end
    @(negedge clk);
    #1;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL wrap_req1 got=%h/%h exp=1/00000000", bus.imem_req, bus.imem_addr); end
    @(negedge clk);
    #1;
    total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'hFFFF_FFFC || bus.id_pc4 !== 32'h0 || bus.id_instr !== 32'hFFFF_FFFF) begin
      bad++; $display("[TB] FAIL wrap_id got=%h/%h/%h/%h exp=1/fffffffc/00000000/ffffffff", bus.id_valid, bus.id_pc, bus.id_pc4, bus.id_instr);
    end
  endtask

  task automatic test_midreset;
    do_reset(1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (bus.id_valid !== 1'b0 || bus.id_instr !== 32'h13 || bus.id_pc !== 32'h0 || bus.id_pc4 !== 32'h4) begin
      bad++; $display("[TB] FAIL mid_async got=%h/%h/%h/%h exp=0/00000013/0/4", bus.id_valid, bus.id_instr, bus.id_pc, bus.id_pc4);
    end
    total++; if (bus.imem_addr !== 32'h100) begin bad++; $display("[TB] FAIL mid_addr got=%h exp=00000100", bus.imem_addr); end
    stale_inject = 1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin bad++; $display("[TB] FAIL mid_req got=%h/%h exp=1/00000100", bus.imem_req, bus.imem_addr); end
    @(negedge clk);
    #1;
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_stale got=%h/%h exp=0", bus.id_valid, bus.id_instr); end
    @(negedge clk);
    #1;
    total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h100 || bus.id_instr !== 32'h113) begin bad++; $display("[TB] FAIL mid_first got=%h/%h/%h exp=1/00000100/00000113", bus.id_valid, bus.id_pc, bus.id_instr); end
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    test_reset();
    test_startup();
    test_stall();
    test_redirect_inflight();
    test_stall_redirect();
    test_wrap();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
